// File: rtl/cam_dvp_capture_pkg.sv
// Shared types and constants for the DVP capture front-end.
// Optional statistics outputs are enabled by defining CAM_CAPTURE_STATS_EN.
package cam_pkg;

  localparam int PIX_X_W = 11;
  localparam int PIX_Y_W = 10;

  localparam int ERR_W     = 3;
  localparam int ERR_ODD   = 0;
  localparam int ERR_LEN   = 1;
  localparam int ERR_LINES = 2;

  typedef enum logic [1:0] {
    ST_SETTLE  = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_ACTIVE  = 2'd2
  } cam_state_e;

endpackage

// File: rtl/cam_dvp_capture_if.sv
// Pixel stream produced by the capture front-end toward the frame-buffer writer.
// No back-pressure: the slave must take every pix_valid strobe.
interface cam_dvp_capture_if;
  import cam_pkg::*;

  logic               pix_valid;
  logic [15:0]        pix_data;
  logic               pix_sof;
  logic               pix_eol;
  logic [PIX_X_W-1:0] pix_x;
  logic [PIX_Y_W-1:0] pix_y;

  modport master (
    output pix_valid, pix_data, pix_sof, pix_eol, pix_x, pix_y
  );

  modport slave (
    input pix_valid, pix_data, pix_sof, pix_eol, pix_x, pix_y
  );

endinterface

// File: rtl/cam_dvp_capture_sync_edge.sv
// Registers the sensor href/vsync once and derives vsync-start, frame-start
// and line-end pulses from the registered copies, with vsync polarity applied.
module cam_sync_edge #(
  parameter bit VS_POL = 1'b1
) (
  input  logic cam_pclk,
  input  logic rst,
  input  logic cam_href,
  input  logic cam_vsync,
  output logic href_r,
  output logic vs_start,
  output logic frame_start,
  output logic href_fall
);

  logic href_q, href_d;
  logic href_prev_q, href_prev_d;
  logic vs_q, vs_d;
  logic vs_prev_q, vs_prev_d;
  logic vs_act, vs_act_prev;

  always_comb begin
    href_d      = cam_href;
    href_prev_d = href_q;
    vs_d        = cam_vsync;
    vs_prev_d   = vs_q;
  end

  // vsync history resets to the inactive level so reset release is not an edge
  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      href_q      <= 1'b0;
      href_prev_q <= 1'b0;
      vs_q        <= ~VS_POL;
      vs_prev_q   <= ~VS_POL;
    end else begin
      href_q      <= href_d;
      href_prev_q <= href_prev_d;
      vs_q        <= vs_d;
      vs_prev_q   <= vs_prev_d;
    end
  end

  assign vs_act      = (vs_q == VS_POL);
  assign vs_act_prev = (vs_prev_q == VS_POL);

  assign href_r      = href_q;
  assign vs_start    = vs_act & ~vs_act_prev;
  assign frame_start = ~vs_act & vs_act_prev;
  assign href_fall   = href_prev_q & ~href_q;

endmodule

// File: rtl/cam_dvp_capture.sv
// DVP capture: pairs sensor bytes into RGB565 pixels with frame/line markers.
// Define CAM_CAPTURE_STATS_EN to add the line/frame statistics outputs.
//
// state      | meaning
// SETTLE     | discarding frames after reset until SKIP_FRAMES frame starts seen
// WAIT_VS    | waiting for the next frame start
// ACTIVE     | capturing pixels until the next vsync start
module cam_dvp_capture
  import cam_pkg::*;
#(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int SKIP_FRAMES = 10,
  parameter bit VS_POL      = 1'b1,
  parameter bit BYTE_SWAP   = 1'b0
) (
  input  logic             cam_pclk,
  input  logic             rst,
  input  logic             cam_href,
  input  logic             cam_vsync,
  input  logic [7:0]       cam_data,
  input  logic             err_clr,
  cam_dvp_capture_if.master pix,
  output logic             frame_done,
  output logic [ERR_W-1:0] err_flags
`ifdef CAM_CAPTURE_STATS_EN
  ,
  output logic [PIX_X_W-1:0] stat_line_len,
  output logic [PIX_Y_W-1:0] stat_frame_lines,
  output logic [15:0]        stat_frames
`endif
);

  localparam logic [PIX_X_W-1:0] H_LIM = PIX_X_W'(H_ACTIVE);
  localparam logic [PIX_Y_W-1:0] V_LIM = PIX_Y_W'(V_ACTIVE);
  localparam logic [PIX_X_W-1:0] X_MAX = '1;
  localparam logic [PIX_Y_W-1:0] Y_MAX = '1;

  logic href_r, vs_start, frame_start, href_fall;

  cam_sync_edge #(.VS_POL(VS_POL)) u_sync_edge (
    .cam_pclk    (cam_pclk),
    .rst         (rst),
    .cam_href    (cam_href),
    .cam_vsync   (cam_vsync),
    .href_r      (href_r),
    .vs_start    (vs_start),
    .frame_start (frame_start),
    .href_fall   (href_fall)
  );

  cam_state_e         state_q, state_d;
  logic [7:0]         skip_cnt_q, skip_cnt_d;
  logic               fs_seen_q, fs_seen_d;
  logic [7:0]         data_q, data_d;
  logic [7:0]         byte_q, byte_d;
  logic               phase_q, phase_d;
  logic [PIX_X_W-1:0] x_q, x_d;
  logic [PIX_Y_W-1:0] y_q, y_d;
  logic               pix_valid_q, pix_valid_d;
  logic [15:0]        pix_data_q, pix_data_d;
  logic               pix_sof_q, pix_sof_d;
  logic               pix_eol_q, pix_eol_d;
  logic [PIX_X_W-1:0] pix_x_q, pix_x_d;
  logic [PIX_Y_W-1:0] pix_y_q, pix_y_d;
  logic               frame_done_q, frame_done_d;
  logic [ERR_W-1:0]   err_q, err_d, err_set;
`ifdef CAM_CAPTURE_STATS_EN
  logic [PIX_X_W-1:0] stat_line_len_q, stat_line_len_d;
  logic [PIX_Y_W-1:0] stat_frame_lines_q, stat_frame_lines_d;
  logic [15:0]        stat_frames_q, stat_frames_d;
`endif

  always_comb begin
    state_d      = state_q;
    skip_cnt_d   = skip_cnt_q;
    fs_seen_d    = fs_seen_q | frame_start;
    data_d       = cam_data;
    byte_d       = byte_q;
    phase_d      = phase_q;
    x_d          = x_q;
    y_d          = y_q;
    pix_valid_d  = 1'b0;
    pix_data_d   = pix_data_q;
    pix_sof_d    = 1'b0;
    pix_eol_d    = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    frame_done_d = 1'b0;
    err_set      = '0;
`ifdef CAM_CAPTURE_STATS_EN
    stat_line_len_d    = stat_line_len_q;
    stat_frame_lines_d = stat_frame_lines_q;
    stat_frames_d      = stat_frames_q;
`endif

    case (state_q)
      ST_SETTLE: begin
        if (SKIP_FRAMES == 0) begin
          state_d = ST_WAIT_VS;
        end else if (frame_start) begin
          if (int'(skip_cnt_q) + 1 >= SKIP_FRAMES) state_d = ST_WAIT_VS;
          else skip_cnt_d = skip_cnt_q + 8'd1;
        end
      end

      ST_WAIT_VS: begin
        if (frame_start) state_d = ST_ACTIVE;
      end

      ST_ACTIVE: begin
        phase_d = href_r ? ~phase_q : 1'b0;

        // a vsync start inside a line truncates it: no pixel from this pair
        if (href_r && !vs_start) begin
          if (!phase_q) begin
            byte_d = data_q;
          end else begin
            if (x_q < H_LIM && y_q < V_LIM) begin
              pix_valid_d = 1'b1;
              pix_data_d  = BYTE_SWAP ? {data_q, byte_q} : {byte_q, data_q};
              pix_x_d     = x_q;
              pix_y_d     = y_q;
              pix_sof_d   = (x_q == '0) && (y_q == '0);
              pix_eol_d   = (x_q == H_LIM - 1'b1);
            end
            if (x_q != X_MAX) x_d = x_q + 1'b1;
          end
        end

        if (href_fall) begin
          if (phase_q)      err_set[ERR_ODD] = 1'b1;
          if (x_q != H_LIM) err_set[ERR_LEN] = 1'b1;
          x_d = '0;
          if (y_q != Y_MAX) y_d = y_q + 1'b1;
`ifdef CAM_CAPTURE_STATS_EN
          stat_line_len_d = x_q;
`endif
        end

        // y_d already includes a line end landing in the same cycle
        if (vs_start) begin
          if (href_r) err_set[ERR_LEN] = 1'b1;
          if (fs_seen_q && y_d != V_LIM) err_set[ERR_LINES] = 1'b1;
`ifdef CAM_CAPTURE_STATS_EN
          stat_frame_lines_d = y_d;
          stat_frames_d      = stat_frames_q + 16'd1;
`endif
          frame_done_d = 1'b1;
          x_d          = '0;
          y_d          = '0;
          phase_d      = 1'b0;
          state_d      = ST_WAIT_VS;
        end
      end

      default: state_d = ST_SETTLE;
    endcase

    err_d = (err_clr ? '0 : err_q) | err_set;
  end

  always_ff @(posedge cam_pclk) begin
    if (rst) begin
      state_q      <= ST_SETTLE;
      skip_cnt_q   <= '0;
      fs_seen_q    <= 1'b0;
      data_q       <= '0;
      byte_q       <= '0;
      phase_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_sof_q    <= 1'b0;
      pix_eol_q    <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      frame_done_q <= 1'b0;
      err_q        <= '0;
`ifdef CAM_CAPTURE_STATS_EN
      stat_line_len_q    <= '0;
      stat_frame_lines_q <= '0;
      stat_frames_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      skip_cnt_q   <= skip_cnt_d;
      fs_seen_q    <= fs_seen_d;
      data_q       <= data_d;
      byte_q       <= byte_d;
      phase_q      <= phase_d;
      x_q          <= x_d;
      y_q          <= y_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      pix_sof_q    <= pix_sof_d;
      pix_eol_q    <= pix_eol_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
`ifdef CAM_CAPTURE_STATS_EN
      stat_line_len_q    <= stat_line_len_d;
      stat_frame_lines_q <= stat_frame_lines_d;
      stat_frames_q      <= stat_frames_d;
`endif
    end
  end

  assign pix.pix_valid = pix_valid_q;
  assign pix.pix_data  = pix_data_q;
  assign pix.pix_sof   = pix_sof_q;
  assign pix.pix_eol   = pix_eol_q;
  assign pix.pix_x     = pix_x_q;
  assign pix.pix_y     = pix_y_q;
  assign frame_done    = frame_done_q;
  assign err_flags     = err_q;
`ifdef CAM_CAPTURE_STATS_EN
  assign stat_line_len    = stat_line_len_q;
  assign stat_frame_lines = stat_frame_lines_q;
  assign stat_frames      = stat_frames_q;
`endif

endmodule

// File: doc/cam_dvp_capture.md
# cam_dvp_capture

DVP capture front-end for the 8-bit parallel camera bus. It runs in the `cam_pclk` domain and pairs sensor bytes into RGB565 pixels. It frames them with start-of-frame and end-of-line markers, discards frames while the sensor settles after reset, and reports framing errors. It sits directly upstream of the frame-buffer write path that the VGA output reads.

## Interface
- `H_ACTIVE`, 640: expected pixels per line.
- `V_ACTIVE`, 480: expected lines per frame.
- `SKIP_FRAMES`, 10: whole frames discarded after reset (0..255).
- `VS_POL`, 1: 1 = `cam_vsync` high during the vertical pulse; 0 = low.
- `BYTE_SWAP`, 0: 0 = first byte is pix[15:8]; 1 = first byte is pix[7:0].
- `cam_pclk`, in, 1: sole clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `cam_href`, in, 1: line valid.
- `cam_vsync`, in, 1: frame sync.
- `cam_data`, in, 8: sensor byte.
- `pix_valid`, out, 1: one-cycle pixel strobe.
- `pix_data`, out, 16: RGB565 pixel.
- `pix_sof`, out, 1: qualifies the first pixel of a frame (x=0, y=0).
- `pix_eol`, out, 1: qualifies pixel x=H_ACTIVE-1.
- `pix_x`, out, 11: column of the current pixel.
- `pix_y`, out, 10: row of the current pixel.
- `frame_done`, out, 1: one-cycle pulse at the start of vsync after a captured frame.
- `err_flags`, out, 3: sticky flags. [0] odd byte count in a line; [1] line length ≠ H_ACTIVE; [2] line count ≠ V_ACTIVE.
- `err_clr`, in, 1: clears all of `err_flags`.

## Operation
- Input stage: `cam_href`, `cam_vsync` and `cam_data` are registered once. All logic uses the registered copies (`href_r`, `vs_r`, `data_r`) plus the previous `vs_r` for edge detection.
- "Vsync start" is the edge of `vs_r` into the active level set by `VS_POL`. "Frame start" is the edge out of that level.
- FSM states:
  - SETTLE: counts frame starts; moves to WAIT_VS when the count reaches `SKIP_FRAMES`. Goes directly to WAIT_VS if `SKIP_FRAMES`=0.
  - WAIT_VS: waits for a frame start, then moves to ACTIVE.
  - ACTIVE: captures pixels. On vsync start: checks the line count, pulses `frame_done`, clears counters and returns to WAIT_VS.
- Byte pairing, in ACTIVE only:
  - A phase bit toggles each cycle `href_r`=1.
  - Phase 0 stores the byte.
  - Phase 1 forms the pixel, honouring `BYTE_SWAP`.
  - The phase bit clears whenever `href_r`=0.
- Line end is the falling edge of `href_r`:
  - If phase=1, set err[0] and drop the orphan byte.
  - If x ≠ H_ACTIVE, set err[1].
  - Then x←0 and y←y+1.
- Pixels with x ≥ H_ACTIVE, or in lines with y ≥ V_ACTIVE, are not emitted. They are still counted; x and y saturate at their maximum widths.
- Line check at vsync start: if y ≠ V_ACTIVE, set err[2]. The check is skipped for the first frame after leaving SETTLE only if no frame start has yet been observed.
- Vsync start while `href_r`=1: the line is truncated, err[1] is set, and no further pixel is emitted.
- Sticky flags: set has priority over `err_clr` in the same cycle.

## Timing
- Latency: the second byte of a pair is on `cam_data` at edge k, is registered at k, and `pix_valid` is high in the cycle after edge k+1.
- `pix_data`, `pix_x`, `pix_y`, `pix_sof` and `pix_eol` are valid only with `pix_valid`.
- Maximum rate is one pixel per 2 clocks. There is no back-pressure; the consumer must accept every strobe.
- `frame_done` is high in the cycle after the edge that registers the vsync start.
- Reset values: every output 0, FSM in SETTLE, counters and phase 0.
- Reset asserted mid-frame: state returns to SETTLE and the settle skip restarts.

## Configuration
- `CAM_CAPTURE_STATS_EN` defined: adds outputs `stat_line_len` (11 bits, last measured line length) and `stat_frame_lines` (10 bits, last measured line count), updated at each line end and vsync start. Adds `stat_frames` (16 bits, wrapping count of captured frames).
- Not defined: these ports and registers are absent. All other behaviour is identical.

## Structure
- `cam_pkg` holds:
  - the FSM state enum (SETTLE, WAIT_VS, ACTIVE);
  - the error-bit index constants;
  - the `pix_x`/`pix_y` width constants.
- One sub-module, `cam_sync_edge`: registers vsync and href and outputs the start/end pulses with `VS_POL` applied. Byte pairing, counters and the FSM stay in the top of this block.

## Test plan
- Reset then `SKIP_FRAMES`=2 with three 4×2 frames (H_ACTIVE=4, V_ACTIVE=2) → no `pix_valid` for frames 1–2. Frame 3 gives 8 strobes; the first has `pix_sof`=1 with x=0, y=0; `frame_done` pulses once; `err_flags`=0.
- Bytes 0xF8,0x1F then 0x07,0xE0 with `BYTE_SWAP`=0 → pixels 0xF81F and 0x07E0. Repeated with `BYTE_SWAP`=1 → 0x1FF8 and 0xE007. Each `pix_valid` appears 2 cycles after its second byte.
- Line of 7 bytes (odd) → 3 pixels emitted; err[0]=1 and err[1]=1; the next line starts at x=0.
- Line of 12 bytes with H_ACTIVE=4 → 4 pixels, `pix_eol` on x=3, err[1]=1. Then `err_clr` → `err_flags`=0.
- Frame of 3 lines with V_ACTIVE=2 → third line suppressed, err[2]=1 at vsync start.
- Assert `rst` mid-line in ACTIVE → all outputs 0 the next cycle; the skip count restarts and `SKIP_FRAMES` full frames are discarded again.
